// File: rtl/img_pkg.sv
// Frame geometry and transmit FSM encoding shared by the capture and transmit sides
// of the camera/SRAM frame path.
package img_pkg;

    localparam int unsigned PIX_W       = 16;
    localparam int unsigned IMG_ROW_DEF = 8;
    localparam int unsigned IMG_COL_DEF = 512;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLead  = 4'd1,
        StLine  = 4'd2,
        StHbl   = 4'd3,
        StTrail = 4'd4,
        StDone  = 4'd5
    } tx_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_frame_tx_if.sv
// SRAM read bus plus the CMOS-style pixel stream produced by the frame transmitter.
interface sram_frame_tx_if #(
    parameter int unsigned ADDR_W = 18
);
    import img_pkg::*;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_oe;
    logic              sram_we;
    logic              sram_cs;
    logic [1:0]        sram_byte;
    wire  [PIX_W-1:0]  sram_data;

    logic              tx_frame_valid;
    logic              tx_line_valid;
    logic              tx_data_en;
    logic [PIX_W-1:0]  tx_data;

    // The transmitter only ever samples sram_data, so it sees it as an input.
    modport master (
        output sram_addr, sram_oe, sram_we, sram_cs, sram_byte,
        input  sram_data,
        output tx_frame_valid, tx_line_valid, tx_data_en, tx_data
    );

    modport slave (
        input  sram_addr, sram_oe, sram_we, sram_cs, sram_byte,
        output sram_data,
        input  tx_frame_valid, tx_line_valid, tx_data_en, tx_data
    );

endinterface

// File: rtl/sram_rd_port.sv
// Registered read-only port to the async SRAM: one address per rd_en cycle,
// data returned with a one-cycle valid on the following edge.
module sram_rd_port
    import img_pkg::*;
#(
    parameter int unsigned ADDR_W = 18
) (
    input  logic              cmos_pclk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_cs,
    output logic [1:0]        sram_byte,
    input  logic [PIX_W-1:0]  sram_data,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid
);

    logic [ADDR_W-1:0] addr_q;
    logic              oe_q;
    logic [PIX_W-1:0]  data_q;
    logic              valid_q;

    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            addr_q  <= '0;
            oe_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            oe_q <= ~rd_en;
            if (rd_en) begin
                addr_q <= rd_addr;
            end
            // Sample on the edge after the address was issued; hold otherwise.
            valid_q <= ~oe_q;
            if (!oe_q) begin
                data_q <= sram_data;
            end
        end
    end

    assign sram_addr = addr_q;
    assign sram_oe   = oe_q;
    assign sram_we   = 1'b1;
    assign sram_cs   = 1'b0;
    assign sram_byte = 2'b00;
    assign rd_data   = data_q;
    assign rd_valid  = valid_q;

endmodule

// File: rtl/sram_frame_tx.sv
// Replays one IMG_ROW x IMG_COL frame from SRAM as a frame/line-valid pixel stream
// with programmable lead, horizontal and trail blanking.
module sram_frame_tx
    import img_pkg::*;
#(
    parameter int unsigned IMG_ROW = IMG_ROW_DEF,
    parameter int unsigned IMG_COL = IMG_COL_DEF,
    parameter int unsigned HBLANK  = 16,
    parameter int unsigned VLEAD   = 4,
    parameter int unsigned VTRAIL  = 4,
    parameter int unsigned ADDR_W  = 18
) (
    input  logic              cmos_pclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    sram_frame_tx_if.master   bus
);

    localparam int unsigned COL_W = $clog2(IMG_COL);
    localparam int unsigned ROW_W = $clog2(IMG_ROW) + 1;
    localparam int unsigned BLK_W = $clog2(max3(HBLANK, VLEAD, VTRAIL) + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_COL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_ROW - 1);
    localparam logic [BLK_W-1:0] LEAD_LAST  = BLK_W'(VLEAD - 1);
    localparam logic [BLK_W-1:0] HBL_LAST   = BLK_W'(HBLANK - 1);
    localparam logic [BLK_W-1:0] TRAIL_LAST = BLK_W'(VTRAIL - 1);

    tx_state_e         state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [BLK_W-1:0]  blk_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              fv_q;
    logic              issue;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;

    // An address is issued on every edge that lands in LINE, so sram_oe is low
    // exactly during the LINE cycles and data follows one cycle later.
    always_comb begin
        issue = 1'b0;
        case (state_q)
            StLead:  issue = (blk_q == LEAD_LAST);
            StHbl:   issue = (blk_q == HBL_LAST);
            StLine:  issue = (col_q != COL_LAST);
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            blk_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        busy_q  <= 1'b1;
                        fv_q    <= 1'b1;
                        blk_q   <= '0;
                        row_q   <= '0;
                        state_q <= StLead;
                    end
                end
                StLead: begin
                    if (blk_q == LEAD_LAST) begin
                        col_q   <= '0;
                        state_q <= StLine;
                    end else begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end
                StLine: begin
                    col_q <= col_q + COL_W'(1);
                    if (col_q == COL_LAST) begin
                        row_q   <= row_q + ROW_W'(1);
                        blk_q   <= '0;
                        state_q <= (row_q == ROW_LAST) ? StTrail : StHbl;
                    end
                end
                StHbl: begin
                    if (blk_q == HBL_LAST) begin
                        col_q   <= '0;
                        state_q <= StLine;
                    end else begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end
                StTrail: begin
                    if (blk_q == TRAIL_LAST) begin
                        state_q <= StDone;
                    end else begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end
                StDone: begin
                    fv_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sram_rd_port #(
        .ADDR_W (ADDR_W)
    ) u_rd_port (
        .cmos_pclk (cmos_pclk),
        .rst       (rst),
        .rd_en     (issue),
        .rd_addr   (addr_q),
        .sram_addr (bus.sram_addr),
        .sram_oe   (bus.sram_oe),
        .sram_we   (bus.sram_we),
        .sram_cs   (bus.sram_cs),
        .sram_byte (bus.sram_byte),
        .sram_data (bus.sram_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    assign busy               = busy_q;
    assign frame_done         = done_q;
    assign bus.tx_frame_valid = fv_q;
    assign bus.tx_line_valid  = rd_valid;
    assign bus.tx_data_en     = rd_valid;
    assign bus.tx_data        = rd_data;

endmodule

// File: tb/tb_sram_frame_tx.sv
// Directed bench for sram_frame_tx: small frames with hand-derived waveforms, address
// wrap, ignored starts, mid-frame reset, and a full default-size frame scoreboard.
module tb_sram_frame_tx;
    import img_pkg::*;

    localparam logic [17:0] BASE_C = 18'h12345;

    logic cmos_pclk = 1'b0;
    always #5 cmos_pclk = ~cmos_pclk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // DUT A: 2x4 frame, HBLANK 2, VLEAD 1, VTRAIL 1; SRAM word value = address
    logic        rst_a = 1'b1, start_a = 1'b0, busy_a, done_a;
    logic [17:0] base_a = '0;
    sram_frame_tx_if #(.ADDR_W(18)) bus_a ();
    assign bus_a.sram_data = bus_a.sram_oe ? 16'hDEAD : bus_a.sram_addr[15:0];

    sram_frame_tx #(
        .IMG_ROW (2), .IMG_COL (4), .HBLANK (2), .VLEAD (1), .VTRAIL (1), .ADDR_W (18)
    ) dut_a (
        .cmos_pclk  (cmos_pclk),
        .rst        (rst_a),
        .start      (start_a),
        .base_addr  (base_a),
        .busy       (busy_a),
        .frame_done (done_a),
        .bus        (bus_a)
    );

    // DUT B: single 4-pixel line, used for address wrap
    logic        rst_b = 1'b1, start_b = 1'b0, busy_b, done_b;
    logic [17:0] base_b = '0;
    sram_frame_tx_if #(.ADDR_W(18)) bus_b ();
    assign bus_b.sram_data = bus_b.sram_oe ? 16'hDEAD : bus_b.sram_addr[15:0];

    sram_frame_tx #(
        .IMG_ROW (1), .IMG_COL (4), .HBLANK (2), .VLEAD (1), .VTRAIL (1), .ADDR_W (18)
    ) dut_b (
        .cmos_pclk  (cmos_pclk),
        .rst        (rst_b),
        .start      (start_b),
        .base_addr  (base_b),
        .busy       (busy_b),
        .frame_done (done_b),
        .bus        (bus_b)
    );

    // DUT C: default geometry, random SRAM content
    logic        rst_c = 1'b1, start_c = 1'b0, busy_c, done_c;
    logic [17:0] base_c = '0;
    logic [15:0] rnd_mem [4096];
    sram_frame_tx_if #(.ADDR_W(18)) bus_c ();
    assign bus_c.sram_data = bus_c.sram_oe ? 16'hDEAD : rnd_mem[12'(bus_c.sram_addr - BASE_C)];

    sram_frame_tx dut_c (
        .cmos_pclk  (cmos_pclk),
        .rst        (rst_c),
        .start      (start_c),
        .base_addr  (base_c),
        .busy       (busy_c),
        .frame_done (done_c),
        .bus        (bus_c)
    );

    // Per-cycle history of DUT A; cycle 0 is the first cycle after the start edge.
    logic [63:0] fv_h, lv_h, de_h, oe_h, done_h, busy_h;
    logic [15:0] data_h [64];
    logic [17:0] addr_h [64];
    logic        misc_ok;

    task automatic capture_a(input int n_cyc, input int st1, input int st2, input int st3,
                             input int rst_cyc);
        fv_h = '0; lv_h = '0; de_h = '0; oe_h = '0; done_h = '0; busy_h = '0;
        misc_ok = 1'b1;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge cmos_pclk);
            start_a   = (k == st1) || (k == st2) || (k == st3);
            rst_a     = (k == rst_cyc);
            fv_h[k]   = bus_a.tx_frame_valid;
            lv_h[k]   = bus_a.tx_line_valid;
            de_h[k]   = bus_a.tx_data_en;
            oe_h[k]   = ~bus_a.sram_oe;
            done_h[k] = done_a;
            busy_h[k] = busy_a;
            data_h[k] = bus_a.tx_data;
            addr_h[k] = bus_a.sram_addr;
            if (bus_a.sram_we !== 1'b1 || bus_a.sram_cs !== 1'b0 || bus_a.sram_byte !== 2'b00)
                misc_ok = 1'b0;
        end
        start_a = 1'b0;
        rst_a   = 1'b0;
    endtask

    task automatic check_single_a(input string tag);
        check({tag, "_fv"},    fv_h,   span(0, 12));
        check({tag, "_busy"},  busy_h, span(0, 12));
        check({tag, "_de"},    de_h,   span(2, 5) | span(8, 11));
        check({tag, "_lv"},    lv_h,   span(2, 5) | span(8, 11));
        check({tag, "_oe_n"},  oe_h,   span(1, 4) | span(7, 10));
        check({tag, "_done"},  done_h, span(13, 13));
        check({tag, "_addr0"}, 64'(addr_h[1]), 64'h100);
        for (int i = 0; i < 8; i++)
            check({tag, "_pix"}, 64'(data_h[2 + i + ((i >= 4) ? 2 : 0)]), 64'(16'h100 + i));
        check({tag, "_ctrl"}, 64'(misc_ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rnd_mem[i] = 16'($urandom);

        // Reset state
        repeat (3) @(negedge cmos_pclk);
        check("rst_busy",  64'(busy_a), 64'd0);
        check("rst_done",  64'(done_a), 64'd0);
        check("rst_addr",  64'(bus_a.sram_addr), 64'd0);
        check("rst_oe",    64'(bus_a.sram_oe), 64'd1);
        check("rst_we",    64'(bus_a.sram_we), 64'd1);
        check("rst_cs",    64'(bus_a.sram_cs), 64'd0);
        check("rst_byte",  64'(bus_a.sram_byte), 64'd0);
        check("rst_fv",    64'(bus_a.tx_frame_valid), 64'd0);
        check("rst_lv",    64'(bus_a.tx_line_valid), 64'd0);
        check("rst_de",    64'(bus_a.tx_data_en), 64'd0);
        check("rst_data",  64'(bus_a.tx_data), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge cmos_pclk);

        // Frame 1 with starts mid-line (3) and during DONE (12) ignored, then a start the
        // cycle after frame_done (14) giving a second frame from cycle 15.
        base_a  = 18'h100;
        start_a = 1'b1;
        capture_a(32, 3, 12, 14, -1);
        check("a_fv",   fv_h,   span(0, 12) | span(15, 27));
        check("a_busy", busy_h, span(0, 12) | span(15, 27));
        check("a_de",   de_h,   span(2, 5) | span(8, 11) | span(17, 20) | span(23, 26));
        check("a_lv",   lv_h,   span(2, 5) | span(8, 11) | span(17, 20) | span(23, 26));
        check("a_oe_n", oe_h,   span(1, 4) | span(7, 10) | span(16, 19) | span(22, 25));
        check("a_done", done_h, span(13, 13) | span(28, 28));
        check("a_addr_first_oe", 64'(addr_h[1]), 64'h100);
        check("a_data_hold", 64'(data_h[13]), 64'h107);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++)
                check("a_pix", 64'(data_h[f * 15 + 2 + i + ((i >= 4) ? 2 : 0)]),
                      64'(16'h100 + i));
        check("a_ctrl", 64'(misc_ok), 64'd1);

        // Reset during pixel 2 of line 1 (cycle 10)
        repeat (2) @(negedge cmos_pclk);
        start_a = 1'b1;
        capture_a(18, -1, -1, -1, 10);
        check("r_fv",    fv_h,   span(0, 10));
        check("r_busy",  busy_h, span(0, 10));
        check("r_de",    de_h,   span(2, 5) | span(8, 10));
        check("r_oe_n",  oe_h,   span(1, 4) | span(7, 10));
        check("r_done",  done_h, 64'd0);
        check("r_pix2",  64'(data_h[10]), 64'h106);
        check("r_data0", 64'(data_h[11]), 64'd0);
        check("r_addr0", 64'(addr_h[11]), 64'd0);

        // Complete frame after the reset
        start_a = 1'b1;
        capture_a(16, -1, -1, -1, -1);
        check_single_a("post_rst");

        // Address wrap on DUT B
        begin
            logic [17:0] addr_q[$];
            logic [15:0] pix_q[$];
            int          fv_cnt, done_cnt;
            fv_cnt = 0; done_cnt = 0;
            base_b  = 18'h3FFFE;
            start_b = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge cmos_pclk);
                start_b = 1'b0;
                if (!bus_b.sram_oe) addr_q.push_back(bus_b.sram_addr);
                if (bus_b.tx_data_en) pix_q.push_back(bus_b.tx_data);
                if (bus_b.tx_frame_valid) fv_cnt++;
                if (done_b) done_cnt++;
            end
            check("b_naddr", 64'(addr_q.size()), 64'd4);
            check("b_npix",  64'(pix_q.size()), 64'd4);
            if (addr_q.size() == 4 && pix_q.size() == 4) begin
                check("b_addr0", 64'(addr_q[0]), 64'h3FFFE);
                check("b_addr1", 64'(addr_q[1]), 64'h3FFFF);
                check("b_addr2", 64'(addr_q[2]), 64'h00000);
                check("b_addr3", 64'(addr_q[3]), 64'h00001);
                check("b_pix0",  64'(pix_q[0]), 64'hFFFE);
                check("b_pix3",  64'(pix_q[3]), 64'h0001);
            end
            check("b_fv_len", 64'(fv_cnt), 64'd7);
            check("b_done",   64'(done_cnt), 64'd1);
        end

        // Default geometry with a pixel scoreboard
        begin
            int   pix_idx, fv_cnt, lines, run, gap;
            logic lv_prev, c_done, we_bad, de_lv_bad;
            pix_idx = 0; fv_cnt = 0; lines = 0; run = 0; gap = 0;
            lv_prev = 1'b0; c_done = 1'b0; we_bad = 1'b0; de_lv_bad = 1'b0;
            base_c  = BASE_C;
            start_c = 1'b1;
            for (int k = 0; k < 6000 && !c_done; k++) begin
                @(negedge cmos_pclk);
                start_c = 1'b0;
                if (bus_c.tx_frame_valid) fv_cnt++;
                if (bus_c.sram_we !== 1'b1) we_bad = 1'b1;
                if (bus_c.tx_data_en !== bus_c.tx_line_valid) de_lv_bad = 1'b1;
                if (bus_c.tx_line_valid) begin
                    if (!lv_prev) begin
                        if (lines > 0) check("c_hblank", 64'(gap), 64'd16);
                        lines++;
                        run = 0;
                    end
                    run++;
                end else begin
                    if (lv_prev) begin
                        check("c_line_len", 64'(run), 64'd512);
                        gap = 0;
                    end
                    gap++;
                end
                lv_prev = bus_c.tx_line_valid;
                if (bus_c.tx_data_en) begin
                    if (pix_idx < 4096) check("c_pix", 64'(bus_c.tx_data), 64'(rnd_mem[pix_idx]));
                    pix_idx++;
                end
                if (done_c) c_done = 1'b1;
            end
            check("c_done_seen", 64'(c_done), 64'd1);
            check("c_npix",      64'(pix_idx), 64'd4096);
            check("c_lines",     64'(lines), 64'd8);
            check("c_fv_len",    64'(fv_cnt), 64'd4217);
            check("c_we_high",   64'(we_bad), 64'd0);
            check("c_de_eq_lv",  64'(de_lv_bad), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_frame_tx.md
Name: sram_frame_tx

Overview:
- Transmit side of the camera/SRAM frame path. On a start pulse, reads one IMG_ROW x IMG_COL frame of 16-bit pixels from the external async SRAM.
- Replays the frame as a CMOS-style stream: a frame-valid level, a line-valid level and a per-pixel data enable, with programmable blanking.
- Drives a frame into the capture/processing path for loopback and bench replay, so one frame stored in SRAM can be re-sent without the sensor.

Parameters:
- IMG_ROW, 8: lines per frame, >=1.
- IMG_COL, 512: pixels per line, >=2.
- HBLANK, 16: idle cycles between lines, >=1.
- VLEAD, 4: cycles between the frame_valid rise and the first line, >=1.
- VTRAIL, 4: cycles between the last pixel and the frame_valid fall, >=1.
- ADDR_W, 18: SRAM word address width.

Ports:
- cmos_pclk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send one frame.
- base_addr  in  ADDR_W  SRAM word address of pixel (0,0); latched on an accepted start.
- busy  out  1  high from an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse when the frame ends.
- sram_data  inout  16  SRAM data bus; this block never drives it (always hi-Z) and only samples it.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_oe  out  1  active-low output enable.
- sram_we  out  1  active-low write enable; held at 1.
- sram_cs  out  1  active-low chip select; tied to 0.
- sram_byte  out  2  active-low byte enables; tied to 00.
- tx_frame_valid  out  1  frame envelope.
- tx_line_valid  out  1  high while a line's pixels are on tx_data.
- tx_data_en  out  1  pixel qualifier.
- tx_data  out  16  pixel value.

Behaviour:
- Reset values: busy 0, frame_done 0, sram_addr 0, sram_oe 1, sram_we 1, tx_frame_valid 0, tx_line_valid 0, tx_data_en 0, tx_data 0. All counters are 0 and the FSM is in IDLE.
- Reset has priority over every other input. Asserting rst mid-frame returns all outputs to their reset values at the next edge, with no trailing pixels and no frame_done.
- FSM states: IDLE, LEAD, LINE, HBL, TRAIL, DONE.
- IDLE: start=1 latches base_addr into addr_ptr and sets busy=1 and tx_frame_valid=1. Next state LEAD; the lead counter is cleared.
- LEAD: lasts VLEAD cycles, then goes to LINE with col_cnt=0.
- LINE: lasts exactly IMG_COL cycles. Each cycle it registers sram_addr<=addr_ptr and sram_oe<=0, then increments addr_ptr and col_cnt.
  - After col_cnt reaches IMG_COL-1, row_cnt increments.
  - If row_cnt==IMG_ROW-1 the next state is TRAIL, otherwise HBL.
- Read pipeline: sram_data is sampled on the edge after the address-issue edge, i.e. with 1 cycle of latency.
  - On that edge: tx_data<=sram_data, tx_data_en<=1, tx_line_valid<=1.
  - tx_line_valid and tx_data_en are therefore identical: exactly IMG_COL consecutive high cycles per line, delayed 1 cycle from the LINE state.
  - Outside those cycles tx_data holds its last value and tx_data_en is 0.
- sram_oe returns to 1 on the first non-LINE cycle.
- HBL: lasts HBLANK cycles, then goes to LINE. The blank interval seen on tx_line_valid is exactly HBLANK cycles.
- TRAIL: VTRAIL cycles, counted from the first non-LINE cycle. The final pixel (emitted in TRAIL's first cycle) stays inside the frame envelope. Then go to DONE.
- DONE: single cycle with tx_frame_valid<=0, busy<=0, frame_done<=1; next state IDLE.
- Frame timing: tx_frame_valid is high for VLEAD + IMG_ROW*IMG_COL + (IMG_ROW-1)*HBLANK + VTRAIL + 1 cycles.
- Addressing: pixel (r,c) is read at (base_addr + r*IMG_COL + c) mod 2^ADDR_W, a linear increment that wraps silently at 2^ADDR_W-1 -> 0.
- start while busy is ignored. There is no queueing. A start in the same cycle as DONE is also ignored; a start on the following IDLE cycle is accepted.
- Counter widths: col_cnt is $clog2(IMG_COL), row_cnt is $clog2(IMG_ROW)+1, the blank counter is sized to max(HBLANK,VLEAD,VTRAIL).

Decomposition:
- Shared package img_pkg holds:
  - FSM state encoding (4-bit, matching existing state width).
  - PIX_W=16.
  - Default IMG_ROW/IMG_COL, so capture and transmit agree on frame geometry.
- One natural sub-module, sram_rd_port: it registers addr/oe, keeps sram_data hi-Z, and returns sampled data with a 1-cycle valid. This isolates SRAM timing from the FSM.

Test Plan:
- IMG_ROW=2, IMG_COL=4, HBLANK=2, VLEAD=1, VTRAIL=1, base=0x100, SRAM preloaded with value=address -> tx_data sequence 0x100..0x103, gap, 0x104..0x107. tx_line_valid runs are 4-2-4. tx_frame_valid is high 1+8+2+1+1=13 cycles. One frame_done pulse.
- Latency check -> first tx_data_en occurs exactly 1 cycle after the first sram_oe=0 cycle, and sram_addr at that cycle is 0x100.
- base=0x3FFFE with IMG_ROW=1, IMG_COL=4 -> sram_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- start pulsed mid-line and again coincident with DONE -> no second frame. start one cycle after frame_done -> a new frame starts with tx_frame_valid rising on the next edge.
- rst asserted during pixel 2 of line 1 -> next edge: all tx_* 0, sram_oe 1, busy 0, no frame_done. A new start then produces a complete, correct frame.
- Default parameters, random SRAM content -> a scoreboard captures 8x512 pixels in order. sram_we stays 1 and sram_data is never driven by the DUT throughout.
